// File: rtl/sparse_cell_unit.sv
// Sparse masked-row MAC cell: walks set mask bits one MAC per cycle into a lane accumulator bank, drains via valid/ready.
// Define SPARSE_CELL_SAT_EN to saturate accumulators instead of wrapping.
module sparse_cell_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_WIDTH = 4,
  parameter int NUM_LANES   = 4,
  parameter int ACC_WIDTH   = 4*DATA_WIDTH,
  parameter int LANE_W      = $clog2(NUM_LANES)
) (
  input  logic                           Clk,
  input  logic                           rst,
  input  logic                           In_valid,
  output logic                           In_ready,
  input  logic [BLOCK_WIDTH*DATA_WIDTH-1:0] Input_act_data,
  input  logic [DATA_WIDTH-1:0]          Input_weight,
  input  logic [BLOCK_WIDTH-1:0]         Mask,
  input  logic                           Direction,
  input  logic                           Acc_clear,
  input  logic                           Flush,
  input  logic                           ResultCapture,
  input  logic [NUM_LANES*ACC_WIDTH-1:0] ResultIn,
  output logic                           Out_valid,
  input  logic                           Out_ready,
  output logic [NUM_LANES*ACC_WIDTH-1:0] Result_out
);

  typedef enum logic [1:0] {IDLE, PROC, DRAIN} state_t;

  state_t                           state;
  logic [BLOCK_WIDTH*DATA_WIDTH-1:0] act_r;
  logic signed [DATA_WIDTH-1:0]     wgt_r;
  logic [BLOCK_WIDTH-1:0]           pend;
  logic                             dir_r;
  logic signed [ACC_WIDTH-1:0]      acc [NUM_LANES];

  int                               idx;
  logic [LANE_W-1:0]                lane_sel;
  logic signed [DATA_WIDTH-1:0]     act_cur;
  logic signed [2*DATA_WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0]      prod_ext;
  logic signed [ACC_WIDTH:0]        sum;
  logic signed [ACC_WIDTH-1:0]      acc_next;
  logic [BLOCK_WIDTH-1:0]           pend_next;

  assign In_ready = (state == IDLE) && !rst;

  always_comb begin
    idx = 0;
    for (int i = BLOCK_WIDTH-1; i >= 0; i--) begin
      if (pend[i]) idx = i;
    end
    // Power-of-two lane count: truncation is the modulo.
    lane_sel  = dir_r ? LANE_W'(BLOCK_WIDTH-1-idx) : LANE_W'(idx);
    act_cur   = act_r[idx*DATA_WIDTH +: DATA_WIDTH];
    prod      = act_cur * wgt_r;
    prod_ext  = ACC_WIDTH'(prod);
    sum       = (ACC_WIDTH+1)'(acc[lane_sel]) + (ACC_WIDTH+1)'(prod_ext);
`ifdef SPARSE_CELL_SAT_EN
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
      acc_next = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      acc_next = sum[ACC_WIDTH-1:0];
`else
    acc_next  = sum[ACC_WIDTH-1:0];
`endif
    pend_next = pend & (pend - 1'b1);
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      state      <= IDLE;
      Out_valid  <= 1'b0;
      Result_out <= '0;
      act_r      <= '0;
      wgt_r      <= '0;
      pend       <= '0;
      dir_r      <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) acc[l] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Flush) begin
            for (int l = 0; l < NUM_LANES; l++) begin
              Result_out[l*ACC_WIDTH +: ACC_WIDTH] <= acc[l];
              acc[l] <= '0;
            end
            Out_valid <= 1'b1;
            state     <= DRAIN;
          end else if (ResultCapture) begin
            Result_out <= ResultIn;
            Out_valid  <= 1'b1;
            state      <= DRAIN;
          end else if (In_valid) begin
            act_r <= Input_act_data;
            wgt_r <= Input_weight;
            pend  <= Mask;
            dir_r <= Direction;
            if (Acc_clear) begin
              for (int l = 0; l < NUM_LANES; l++) acc[l] <= '0;
            end
            state <= PROC;
          end
        end
        PROC: begin
          // An empty mask still costs this one cycle, with no MAC.
          if (pend != '0) acc[lane_sel] <= acc_next;
          pend <= pend_next;
          if (pend_next == '0) state <= IDLE;
        end
        DRAIN: begin
          if (Out_ready) begin
            Out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_cell_unit.sv
// Directed bench for sparse_cell_unit with ACC_WIDTH=16; expectations follow SPARSE_CELL_SAT_EN.
module tb_sparse_cell_unit;

  localparam int DW = 8;
  localparam int BW = 4;
  localparam int NL = 4;
  localparam int AW = 16;

  logic              Clk = 1'b0;
  logic              rst;
  logic              In_valid;
  logic              In_ready;
  logic [BW*DW-1:0]  Input_act_data;
  logic [DW-1:0]     Input_weight;
  logic [BW-1:0]     Mask;
  logic              Direction;
  logic              Acc_clear;
  logic              Flush;
  logic              ResultCapture;
  logic [NL*AW-1:0]  ResultIn;
  logic              Out_valid;
  logic              Out_ready;
  logic [NL*AW-1:0]  Result_out;

  int tests  = 0;
  int failed = 0;
  int busy;
  logic [NL*AW-1:0] held;

  sparse_cell_unit #(.DATA_WIDTH(DW), .BLOCK_WIDTH(BW), .NUM_LANES(NL), .ACC_WIDTH(AW)) dut (
    .Clk(Clk), .rst(rst), .In_valid(In_valid), .In_ready(In_ready),
    .Input_act_data(Input_act_data), .Input_weight(Input_weight), .Mask(Mask),
    .Direction(Direction), .Acc_clear(Acc_clear), .Flush(Flush),
    .ResultCapture(ResultCapture), .ResultIn(ResultIn), .Out_valid(Out_valid),
    .Out_ready(Out_ready), .Result_out(Result_out)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one row, then count cycles until In_ready returns (bounded).
  task automatic run_row(input string tag, input logic [BW*DW-1:0] act, input logic [DW-1:0] w,
                         input logic [BW-1:0] m, input logic dir, input logic clr, input int exp_busy);
    Input_act_data = act; Input_weight = w; Mask = m; Direction = dir; Acc_clear = clr;
    In_valid = 1'b1;
    step();
    In_valid = 1'b0;
    busy = 0;
    while (!In_ready && busy < 50) begin
      busy++;
      step();
    end
    check(tag, 64'(busy), 64'(exp_busy));
  endtask

  task automatic flush_check(input string tag, input logic [63:0] exp);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    check({tag, "_ov"}, 64'(Out_valid), 64'd1);
    check({tag, "_res"}, Result_out, exp);
    step();
    check({tag, "_ov_drop"}, 64'(Out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; In_valid = 1'b0; Input_act_data = '0; Input_weight = '0; Mask = '0;
    Direction = 1'b0; Acc_clear = 1'b0; Flush = 1'b0; ResultCapture = 1'b0;
    ResultIn = '0; Out_ready = 1'b1;
    step(); step();
    check("rst_in_ready", 64'(In_ready), 64'd0);
    check("rst_out_valid", 64'(Out_valid), 64'd0);
    check("rst_result", Result_out, 64'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 64'(In_ready), 64'd1);

    // Sparse row: lanes 1 and 3 get 3*2 and -2*2.
    run_row("sparse_busy", {8'hFE, 8'd7, 8'd3, 8'd5}, 8'd2, 4'b1010, 1'b0, 1'b1, 2);
    flush_check("sparse", 64'hFFFC_0000_0006_0000);

    // Empty mask: one busy cycle, no accumulation.
    run_row("empty_busy", {8'd9, 8'd9, 8'd9, 8'd9}, 8'd5, 4'b0000, 1'b0, 1'b0, 1);
    // Reversed direction maps index 0 to lane 3.
    run_row("dir_busy", {24'h0, 8'd10}, 8'hFD, 4'b0001, 1'b1, 1'b0, 1);

    // Backpressure with Flush and In_valid attempted during DRAIN.
    Out_ready = 1'b0;
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    held = Result_out;
    check("dir_res", Result_out, 64'hFFE2_0000_0000_0000);
    for (int c = 0; c < 5; c++) begin
      Flush = (c == 1);
      In_valid = (c == 2);
      Input_act_data = {24'h0, 8'd50}; Input_weight = 8'd1; Mask = 4'b0001;
      Direction = 1'b0; Acc_clear = 1'b0;
      step();
      check("bp_ov", 64'(Out_valid), 64'd1);
      check("bp_hold", Result_out, held);
      check("bp_in_ready", 64'(In_ready), 64'd0);
    end
    Flush = 1'b0; In_valid = 1'b0;
    Out_ready = 1'b1;
    step();
    check("bp_release_ov", 64'(Out_valid), 64'd0);
    check("bp_release_ir", 64'(In_ready), 64'd1);
    flush_check("bp_ignored", 64'd0);

    // Chain pass-through leaves the bank intact.
    run_row("chain_busy", {8'd4, 8'd3, 8'd2, 8'd1}, 8'd1, 4'b1111, 1'b0, 1'b1, 4);
    ResultIn = 64'h0044_0033_0022_0011;
    ResultCapture = 1'b1;
    step();
    ResultCapture = 1'b0;
    check("chain_ov", 64'(Out_valid), 64'd1);
    check("chain_res", Result_out, 64'h0044_0033_0022_0011);
    step();
    check("chain_ov_drop", 64'(Out_valid), 64'd0);
    flush_check("chain_acc", 64'h0004_0003_0002_0001);

    // Overflow: three 127*127 products into a 16-bit lane.
    run_row("ovf_busy0", {24'h0, 8'd127}, 8'd127, 4'b0001, 1'b0, 1'b1, 1);
    run_row("ovf_busy1", {24'h0, 8'd127}, 8'd127, 4'b0001, 1'b0, 1'b0, 1);
    run_row("ovf_busy2", {24'h0, 8'd127}, 8'd127, 4'b0001, 1'b0, 1'b0, 1);
`ifdef SPARSE_CELL_SAT_EN
    flush_check("ovf", 64'h0000_0000_0000_7FFF);
`else
    flush_check("ovf", 64'h0000_0000_0000_BD03);
`endif

    // Reset during the second PROC cycle of a full-mask row.
    Input_act_data = {8'd1, 8'd1, 8'd1, 8'd5}; Input_weight = 8'd1; Mask = 4'b1111;
    Direction = 1'b0; Acc_clear = 1'b1;
    In_valid = 1'b1;
    step();
    In_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("rstproc_in_ready", 64'(In_ready), 64'd0);
    check("rstproc_ov", 64'(Out_valid), 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("rstproc_idle", 64'(In_ready), 64'd1);
    flush_check("rstproc", 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sparse_cell_unit.md
# sparse_cell_unit

Parametrised, handshaked successor to the sparse accelerator's cell unit. It accepts one masked activation row per transaction and walks only the set mask bits, one multiply-accumulate per cycle. Each product goes into a per-lane accumulator bank. On request, it hands the bank, or a neighbour cell's result for chaining, downstream through a valid/ready output stage. It sits in the cell array between the activation/weight feeders and the result collection chain.

## Interface
- DATA_WIDTH, 8, signed activation/weight width
- BLOCK_WIDTH, 4, activations per row (= mask bits)
- NUM_LANES, 4, accumulator lanes; power of two
- ACC_WIDTH, 4*DATA_WIDTH, accumulator width per lane (≥ 2*DATA_WIDTH)
- LANE_W, $clog2(NUM_LANES), lane index width
- Clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- In_valid  in  1  row/weight/mask presented
- In_ready  out  1  cell can accept a row
- Input_act_data  in  BLOCK_WIDTH*DATA_WIDTH  activation i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- Input_weight  in  DATA_WIDTH  signed weight for the row
- Mask  in  BLOCK_WIDTH  bit i = 1 → activation i is nonzero and processed
- Direction  in  1  lane mapping select, sampled at accept
- Acc_clear  in  1  zero all accumulators at accept, before the row's MACs
- Flush  in  1  move accumulators to the output and clear them
- ResultCapture  in  1  load ResultIn into the output (chain pass-through)
- ResultIn  in  NUM_LANES*ACC_WIDTH  upstream neighbour result, lane l at [l*ACC_WIDTH +: ACC_WIDTH]
- Out_valid  out  1  Result_out holds valid data
- Out_ready  in  1  downstream accepts
- Result_out  out  NUM_LANES*ACC_WIDTH  output lanes, same packing as ResultIn

## Operation
- **FSM states:** IDLE, PROC, DRAIN.
- **In_ready:** equals (state==IDLE && !rst).
- **IDLE priority:**
  - Flush: Result_out ← acc, all acc ← 0, go to DRAIN.
  - else ResultCapture: Result_out ← ResultIn, acc untouched, go to DRAIN.
  - else In_valid: accept. Register act row, weight, Mask, Direction. If Acc_clear, zero acc. Go to PROC.
- **PROC:** one cycle per set mask bit, in ascending index order, using a pending-mask register with lowest-set-bit priority.
  - For index i, lane = Direction ? (BLOCK_WIDTH-1-i) mod NUM_LANES : i mod NUM_LANES.
  - acc[lane] ← acc[lane] + sext(act_i × weight), with a signed DATA_WIDTH×DATA_WIDTH full-precision product.
  - Clear bit i. Return to IDLE when the pending mask becomes 0.
  - Mask = 0 still spends exactly one PROC cycle with no accumulator change.
- **Accumulator arithmetic:** two's-complement wrap at ACC_WIDTH, unless the saturation macro is defined (see Configuration).
- **DRAIN:** Result_out and Out_valid are held stable. When Out_valid && Out_ready, Out_valid drops and the FSM goes to IDLE. In DRAIN, Flush, ResultCapture and In_valid are ignored.
- **Reset values:**
  - Outputs: In_ready=0, Out_valid=0, Result_out=0.
  - Internal: acc all 0, state IDLE.
  - Reset in any state aborts the operation with no partial update, including a row mid-PROC.

## Timing
- Accept at edge N (In_valid && In_ready). PROC occupies cycles N+1..N+k, where k = max(1, popcount(Mask)).
- In_ready is low for k cycles and high again in cycle N+k+1.
- Sustained throughput: one row per k+1 cycles.
- MAC result visible in acc at the end edge of its PROC cycle.
- Flush or ResultCapture sampled at IDLE edge M gives Out_valid=1 and Result_out valid in cycle M+1. The earliest output handshake is at edge M+1.
- Inputs are sampled only at the accept edge; changes during PROC have no effect.

## Configuration
- Macro SPARSE_CELL_SAT_EN.
- **Defined:** each accumulate saturates to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
- **Undefined:** modular wrap.
- Handshake, ordering and latency are identical in both builds.

## Test plan
- **Sparse row:** act={−2,7,3,5} (idx3..0), weight=2, Mask=4'b1010, Direction=0, Acc_clear=1.
  - Expect In_ready low for 2 cycles.
  - Then Flush → Result_out lanes {0:0, 1:6, 2:0, 3:−4}, Out_valid one cycle after Flush.
- **Empty mask and direction:**
  - Mask=0 → exactly 1 busy cycle, acc unchanged.
  - Then Mask=4'b0001, act0=10, weight=−3, Direction=1 → lane3 = −30, other lanes 0 after Flush.
- **Backpressure:** Out_ready=0 for 5 cycles after Flush.
  - Expect Out_valid=1 and Result_out constant throughout.
  - A Flush and an In_valid during DRAIN have no effect.
  - Out_ready=1 → Out_valid=0 next cycle, In_ready=1.
- **Chain pass-through:** acc lanes {1,2,3,4}, ResultCapture with ResultIn lanes {0x11,0x22,0x33,0x44}.
  - Expect Result_out = ResultIn.
  - A following Flush outputs {1,2,3,4}.
- **Overflow** (ACC_WIDTH=16): three rows, act0=127, weight=127, Mask=4'b0001.
  - With SPARSE_CELL_SAT_EN: lane0 = 32767.
  - Without: lane0 = −17149.
- **Reset mid-PROC:** rst for 1 cycle during the 2nd PROC cycle of a Mask=4'b1111 row.
  - Expect In_ready=0, Out_valid=0 in the reset cycle.
  - Next Flush outputs all zeros.
